// File: rtl/turn_sched_pkg.sv
// Shared types and constants for the turn-signal scheduler: state codes,
// steps per turn cycle and the switch arbitration rule.
package turn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_HAZ   = 2'd3
    } sched_state_t;

    localparam int STEPS_PER_CYCLE = 4;
    localparam int STEP_IDX_W      = 2;

    // Both turn switches at once is treated as a hazard request.
    function automatic sched_state_t decide(input logic haz, input logic left, input logic right);
        if (haz || (left && right)) return ST_HAZ;
        if (left)                   return ST_LEFT;
        if (right)                  return ST_RIGHT;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/turn_signal_scheduler_tick_prescaler.sv
// Step-cadence prescaler: counts clk cycles while run is high and flags the
// last cycle of each TICK_DIV-long period; clr forces the count back to 0.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_signal_scheduler.sv
// Turn-signal scheduler: arbitrates left/right/hazard switches and drives the
// lamp sequencer. Brake override is built only with TURN_SCHED_BRAKE_EN defined.
module turn_signal_scheduler
    import turn_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       brake,
    output logic       seq_step,
    output logic       seq_left,
    output logic       seq_right,
    output logic       seq_clr,
    output logic       haz_on,
    output logic       brk_l,
    output logic       brk_r,
    output logic [1:0] state_o
);

    localparam logic [STEP_IDX_W-1:0] LAST_STEP = STEP_IDX_W'(STEPS_PER_CYCLE - 1);

    sched_state_t            state_q;
    logic [STEP_IDX_W-1:0]   step_idx_q;
    logic                    haz_on_q;
    logic                    seq_step_q;
    logic                    seq_left_q;
    logic                    seq_right_q;
    logic                    seq_clr_q;
    sched_state_t            decision;
    logic                    tick;

    always_comb decision = decide(hazard_sw, left_sw, right_sw);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (state_q != ST_IDLE),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    // seq_step is a one-cycle strobe with no back-pressure; seq_left/seq_right
    // are meaningful only while seq_step is high and mark step index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_idx_q  <= '0;
            haz_on_q    <= 1'b0;
            seq_step_q  <= 1'b0;
            seq_left_q  <= 1'b0;
            seq_right_q <= 1'b0;
            seq_clr_q   <= 1'b0;
        end else begin
            seq_step_q  <= 1'b0;
            seq_left_q  <= 1'b0;
            seq_right_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q    <= decision;
                    step_idx_q <= '0;
                    haz_on_q   <= 1'b0;
                    seq_clr_q  <= (decision == ST_HAZ);
                end
                ST_LEFT, ST_RIGHT: begin
                    if (tick) begin
                        seq_step_q  <= 1'b1;
                        seq_left_q  <= (state_q == ST_LEFT) && (step_idx_q == '0);
                        seq_right_q <= (state_q == ST_RIGHT) && (step_idx_q == '0);
                        // Direction is only re-evaluated once the lamps are back to off.
                        if (step_idx_q == LAST_STEP) begin
                            state_q    <= decision;
                            step_idx_q <= '0;
                            seq_clr_q  <= (decision == ST_HAZ);
                        end else begin
                            step_idx_q <= step_idx_q + STEP_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (haz_on_q) begin
                            haz_on_q <= 1'b0;
                            if (decision != ST_HAZ) begin
                                state_q   <= decision;
                                seq_clr_q <= 1'b0;
                            end
                        end else begin
                            haz_on_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign seq_step  = seq_step_q;
    assign seq_left  = seq_left_q;
    assign seq_right = seq_right_q;
    assign seq_clr   = seq_clr_q;
    assign haz_on    = haz_on_q;
    assign state_o   = state_q;

`ifdef TURN_SCHED_BRAKE_EN
    assign brk_l = brake && (state_q != ST_LEFT) && (state_q != ST_HAZ);
    assign brk_r = brake && (state_q != ST_RIGHT) && (state_q != ST_HAZ);
`else
    logic brake_unused;
    assign brake_unused = brake;
    assign brk_l        = 1'b0;
    assign brk_r        = 1'b0;
`endif

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Bench for turn_signal_scheduler: vector table, hand-written corner sequences
// and randomized switch activity against a time-based reference model.
module tb_turn_signal_scheduler;

    localparam int TD = 4;
`ifdef TURN_SCHED_BRAKE_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       left_sw, right_sw, hazard_sw, brake;
    logic       seq_step, seq_left, seq_right, seq_clr, haz_on, brk_l, brk_r;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0..3 and clocks elapsed since the current turn
    // cycle / hazard phase began.
    int m_mode, m_age;
    bit m_haz, e_step, e_left, e_right;

    turn_signal_scheduler #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .left_sw   (left_sw),
        .right_sw  (right_sw),
        .hazard_sw (hazard_sw),
        .brake     (brake),
        .seq_step  (seq_step),
        .seq_left  (seq_left),
        .seq_right (seq_right),
        .seq_clr   (seq_clr),
        .haz_on    (haz_on),
        .brk_l     (brk_l),
        .brk_r     (brk_r),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_decide(input logic h, input logic l, input logic r);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_haz = 0;
        e_step = 0; e_left = 0; e_right = 0;
    endtask

    task automatic model_edge();
        int d;
        d = tb_decide(hazard_sw, left_sw, right_sw);
        e_step = 0; e_left = 0; e_right = 0;
        case (m_mode)
            0: begin
                m_mode = d; m_age = 0; m_haz = 0;
            end
            1, 2: begin
                m_age++;
                if (m_age % TD == 0) begin
                    e_step = 1;
                    if (m_age == TD) begin
                        e_left  = (m_mode == 1);
                        e_right = (m_mode == 2);
                    end
                    if (m_age == 4 * TD) begin
                        m_mode = d; m_age = 0;
                    end
                end
            end
            default: begin
                m_age++;
                if (m_age % TD == 0) begin
                    if (m_haz && d != 3) begin
                        m_mode = d; m_age = 0; m_haz = 0;
                    end else begin
                        m_haz = !m_haz;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        bit exp_bl, exp_br;
        exp_bl = BRK_EN && brake && m_mode != 1 && m_mode != 3;
        exp_br = BRK_EN && brake && m_mode != 2 && m_mode != 3;
        check("state_o",   8'(state_o),   8'(m_mode));
        check("seq_step",  8'(seq_step),  8'(e_step));
        check("seq_left",  8'(seq_left),  8'(e_left));
        check("seq_right", 8'(seq_right), 8'(e_right));
        check("seq_clr",   8'(seq_clr),   8'(m_mode == 3));
        check("haz_on",    8'(haz_on),    8'(m_haz));
        check("brk_l",     8'(brk_l),     8'(exp_bl));
        check("brk_r",     8'(brk_r),     8'(exp_br));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        reset = 1'b0;
    endtask

    task automatic set_sw(input logic l, input logic r, input logic h, input logic b);
        left_sw = l; right_sw = r; hazard_sw = h; brake = b;
    endtask

    typedef struct {
        logic l, r, h, b;
        int   hold;
        logic [1:0] st;
        logic clr, hz, stp, sl, sr, bl, br;
    } vec_t;

    localparam int NV = 12;
    vec_t vt[NV];

    initial begin
        int n;
        logic exp_bit;
        set_sw(0, 0, 0, 0);
        reset = 1'b0;

        //        l  r  h  b  hold    st clr hz stp sl sr bl      br
        vt[0]  = '{0, 0, 0, 1, 3,      0, 0, 0, 0, 0, 0, BRK_EN, BRK_EN};
        vt[1]  = '{1, 0, 0, 1, 1,      1, 0, 0, 0, 0, 0, 0,      BRK_EN};
        vt[2]  = '{0, 1, 0, 1, 1,      2, 0, 0, 0, 0, 0, BRK_EN, 0};
        vt[3]  = '{1, 1, 0, 1, 1,      3, 1, 0, 0, 0, 0, 0,      0};
        vt[4]  = '{0, 0, 1, 0, 5,      3, 1, 1, 0, 0, 0, 0,      0};
        vt[5]  = '{0, 0, 1, 0, 9,      3, 1, 0, 0, 0, 0, 0,      0};
        vt[6]  = '{1, 0, 0, 0, TD+1,   1, 0, 0, 1, 1, 0, 0,      0};
        vt[7]  = '{1, 0, 0, 0, 2*TD+1, 1, 0, 0, 1, 0, 0, 0,      0};
        vt[8]  = '{0, 1, 0, 0, TD+1,   2, 0, 0, 1, 0, 1, 0,      0};
        vt[9]  = '{0, 1, 0, 0, 5*TD+1, 2, 0, 0, 1, 0, 1, 0,      0};
        vt[10] = '{1, 0, 1, 0, 1,      3, 1, 0, 0, 0, 0, 0,      0};
        vt[11] = '{1, 0, 0, 0, 6,      1, 0, 0, 0, 0, 0, 0,      0};

        for (int i = 0; i < NV; i++) begin
            set_sw(0, 0, 0, 0);
            apply_reset();
            set_sw(vt[i].l, vt[i].r, vt[i].h, vt[i].b);
            repeat (vt[i].hold) cycle();
            check($sformatf("vec%0d_state", i), 8'(state_o),   8'(vt[i].st));
            check($sformatf("vec%0d_clr", i),   8'(seq_clr),   8'(vt[i].clr));
            check($sformatf("vec%0d_haz", i),   8'(haz_on),    8'(vt[i].hz));
            check($sformatf("vec%0d_step", i),  8'(seq_step),  8'(vt[i].stp));
            check($sformatf("vec%0d_left", i),  8'(seq_left),  8'(vt[i].sl));
            check($sformatf("vec%0d_right", i), 8'(seq_right), 8'(vt[i].sr));
            check($sformatf("vec%0d_brkl", i),  8'(brk_l),     8'(vt[i].bl));
            check($sformatf("vec%0d_brkr", i),  8'(brk_r),     8'(vt[i].br));
        end

        // Left request sampled at clock 2: steps every TD clocks from 2+TD.
        set_sw(0, 0, 0, 0);
        apply_reset();
        cycle();
        left_sw = 1'b1;
        for (int c = 2; c <= 26; c++) begin
            cycle();
            exp_bit = (c >= 2 + TD) && ((c - 2 - TD) % TD == 0);
            check("cadence_step", 8'(seq_step), 8'(exp_bit));
            exp_bit = exp_bit && ((c - 2 - TD) % (4 * TD) == 0);
            check("cadence_left", 8'(seq_left), 8'(exp_bit));
        end

        // A three-clock left pulse still produces one complete cycle.
        set_sw(0, 0, 0, 0);
        apply_reset();
        left_sw = 1'b1;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            cycle();
            if (seq_step) n++;
            if (c == 3) left_sw = 1'b0;
        end
        check("pulse_steps", 8'(n), 8'd4);
        check("pulse_state", 8'(state_o), 8'd0);

        // Left -> right handover at the cycle boundary.
        set_sw(0, 0, 0, 0);
        apply_reset();
        left_sw = 1'b1;
        cycle();
        repeat (2 * TD) cycle();
        set_sw(0, 1, 0, 0);
        repeat (2 * TD - 1) cycle();
        check("handover_hold_left", 8'(state_o), 8'd1);
        cycle();
        check("handover_now_right", 8'(state_o), 8'd2);
        repeat (TD) cycle();
        check("handover_step", 8'(seq_step), 8'd1);
        check("handover_right", 8'(seq_right), 8'd1);
        check("handover_left", 8'(seq_left), 8'd0);

        // Both turn switches from idle: hazard flashing, no steps.
        set_sw(0, 0, 0, 0);
        apply_reset();
        set_sw(1, 1, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            cycle();
            check("haz_nostep", 8'(seq_step), 8'd0);
            exp_bit = (c >= 1 + TD) && (((c - 1 - TD) / TD) % 2 == 0);
            check("haz_phase", 8'(haz_on), 8'(exp_bit));
        end

        // Asynchronous reset right after step index 2.
        set_sw(0, 0, 0, 0);
        apply_reset();
        left_sw = 1'b1;
        cycle();
        repeat (3 * TD) cycle();
        check("pre_reset_step", 8'(seq_step), 8'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_step",  8'(seq_step),  8'd0);
        check("rst_mid_state", 8'(state_o),   8'd0);
        check("rst_mid_left",  8'(seq_left),  8'd0);
        check("rst_mid_clr",   8'(seq_clr),   8'd0);
        check("rst_mid_haz",   8'(haz_on),    8'd0);
        model_reset();
        for (int c = 0; c < 3 * TD; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_hold_step", 8'(seq_step), 8'd0);
        end
        left_sw = 1'b0;
        reset = 1'b0;

        // Randomized switch activity against the model.
        set_sw(0, 0, 0, 0);
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
